// File: rtl/risc_decode_pipe.sv
// Pipelined RISC decode stage: valid/ready in, registered decode out, scoreboard hazard stall.
// Optional hazard-stall counter port stall_cnt is built when DECODE_PERF_EN is defined.
module risc_decode_pipe #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16,
  localparam int NUM_REGS = 2**REG_AW,
  localparam int INSTR_W  = 4 + 3*REG_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_opcode,
  output logic [REG_AW-1:0]   out_opnda,
  output logic [REG_AW-1:0]   out_opndb,
  output logic [REG_AW-1:0]   out_dst,
  output logic                out_uses_a,
  output logic                out_uses_b,
  output logic                out_wr,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_dst,
  output logic [NUM_REGS-1:0] busy_map
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]    stall_cnt
`endif
);

  logic [3:0]          w_opcode;
  logic [REG_AW-1:0]   w_opnda;
  logic [REG_AW-1:0]   w_opndb;
  logic [REG_AW-1:0]   w_dst;
  logic                w_uses_a;
  logic                w_uses_b;
  logic                w_wr;
  logic                w_illegal;
  logic                w_blocked;
  logic                w_accept;
  logic [NUM_REGS-1:0] w_busy_nxt;

  logic                r_out_valid;
  logic [3:0]          r_opcode;
  logic [REG_AW-1:0]   r_opnda;
  logic [REG_AW-1:0]   r_opndb;
  logic [REG_AW-1:0]   r_dst;
  logic                r_uses_a;
  logic                r_uses_b;
  logic                r_wr;
  logic                r_illegal;
  logic [NUM_REGS-1:0] r_busy;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_opcode  = in_instr[INSTR_W-1 -: 4];
    w_opnda   = in_instr[3*REG_AW-1 -: REG_AW];
    w_opndb   = in_instr[2*REG_AW-1 -: REG_AW];
    w_dst     = in_instr[REG_AW-1:0];
    w_uses_a  = 1'b0;
    w_uses_b  = 1'b0;
    w_wr      = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode) inside
      [4'd1:4'd5]: begin
        w_uses_a = 1'b1;
        w_uses_b = 1'b1;
        w_wr     = 1'b1;
      end
      [4'd6:4'd13]: begin
        w_uses_a = 1'b1;
        w_wr     = 1'b1;
      end
      4'd14:   w_illegal = 1'b1;
      4'd15: begin
        w_uses_a = 1'b1;
        w_uses_b = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards look only at the registered scoreboard; a freed register is usable next cycle.
  assign w_blocked = (w_uses_a && r_busy[w_opnda]) ||
                     (w_uses_b && r_busy[w_opndb]) ||
                     (w_wr     && r_busy[w_dst]);
  assign in_ready  = !w_blocked && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  // Clear first, then set, so a same-edge set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid)
      w_busy_nxt[wb_dst] = 1'b0;
    if (w_accept && w_wr)
      w_busy_nxt[w_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_opcode    <= '0;
      r_opnda     <= '0;
      r_opndb     <= '0;
      r_dst       <= '0;
      r_uses_a    <= 1'b0;
      r_uses_b    <= 1'b0;
      r_wr        <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_opcode;
        r_opnda     <= w_opnda;
        r_opndb     <= w_opndb;
        r_dst       <= w_dst;
        r_uses_a    <= w_uses_a;
        r_uses_b    <= w_uses_b;
        r_wr        <= w_wr;
        r_illegal   <= w_illegal;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_opcode  = r_opcode;
  assign out_opnda   = r_opnda;
  assign out_opndb   = r_opndb;
  assign out_dst     = r_dst;
  assign out_uses_a  = r_uses_a;
  assign out_uses_b  = r_uses_b;
  assign out_wr      = r_wr;
  assign out_illegal = r_illegal;
  assign busy_map    = r_busy;

`ifdef DECODE_PERF_EN
  // Counts hazard stalls only; cycles lost to downstream backpressure are excluded.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && w_blocked && (!r_out_valid || out_ready) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_risc_decode_pipe.sv
// Randomised self-checking bench for risc_decode_pipe against a behavioural decode/scoreboard model.
// Define DECODE_PERF_EN for both RTL and bench to also check stall_cnt.
module tb_risc_decode_pipe;

  localparam int REG_AW = 3;
  localparam int CNT_W  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_opnda, out_opndb, out_dst;
  logic        out_uses_a, out_uses_b, out_wr, out_illegal;
  logic        wb_valid;
  logic [2:0]  wb_dst;
  logic [7:0]  busy_map;
`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  risc_decode_pipe #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_opnda(out_opnda), .out_opndb(out_opndb), .out_dst(out_dst),
    .out_uses_a(out_uses_a), .out_uses_b(out_uses_b), .out_wr(out_wr), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .busy_map(busy_map)
`ifdef DECODE_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit       m_valid, m_clean;
  int       m_op, m_a, m_b, m_d;
  bit       m_ua, m_ub, m_wr, m_ill;
  bit       m_busy[8];
  int       m_stall;

  function automatic void classify(input int op, output bit ua, output bit ub,
                                   output bit wr, output bit ill);
    ua = 0; ub = 0; wr = 0; ill = 0;
    if (op >= 1 && op <= 5)       begin ua = 1; ub = 1; wr = 1; end
    else if (op >= 6 && op <= 13) begin ua = 1; wr = 1; end
    else if (op == 15)            begin ua = 1; ub = 1; end
    else if (op == 14)            ill = 1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_clean = 1;
    m_op = 0; m_a = 0; m_b = 0; m_d = 0;
    m_ua = 0; m_ub = 0; m_wr = 0; m_ill = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_stall = 0;
  endtask

  // One clock: drive after the falling edge, check mid-cycle, advance model on the rising edge.
  task automatic step(input bit rs, input bit iv, input logic [12:0] ins,
                      input bit ordy, input bit wbv, input int wbd);
    int  op, a, b, d;
    bit  ua, ub, wr, ill, blk, rdy;
    logic [7:0] exp_busy;
    @(negedge clk);
    rst = rs; in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_valid = wbv; wb_dst = 3'(wbd);
    #1;
    op = int'(ins) / 512;
    a  = (int'(ins) / 64) % 8;
    b  = (int'(ins) / 8) % 8;
    d  = int'(ins) % 8;
    classify(op, ua, ub, wr, ill);
    blk = (ua && m_busy[a]) || (ub && m_busy[b]) || (wr && m_busy[d]);
    rdy = !blk && (!m_valid || ordy);
    exp_busy = '0;
    foreach (m_busy[i]) exp_busy[i] = m_busy[i];
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy_map", 32'(busy_map), 32'(exp_busy));
    if (m_valid || m_clean) begin
      check("fields", {out_opcode, out_opnda, out_opndb, out_dst},
            32'((m_op * 512) + (m_a * 64) + (m_b * 8) + m_d));
      check("flags", {out_uses_a, out_uses_b, out_wr, out_illegal},
            {m_ua, m_ub, m_wr, m_ill});
    end
`ifdef DECODE_PERF_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (iv && blk && (!m_valid || ordy) && m_stall < (1 << CNT_W) - 1)
        m_stall++;
      if (wbv) m_busy[wbd] = 0;
      if (iv && rdy) begin
        m_valid = 1; m_clean = 0;
        m_op = op; m_a = a; m_b = b; m_d = d;
        m_ua = ua; m_ub = ub; m_wr = wr; m_ill = ill;
        if (wr) m_busy[d] = 1;
      end else if (m_valid && ordy) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_dst = '0;
    model_reset();
    step(1, 0, 13'h0000, 0, 0, 0);
    step(0, 0, 13'h0000, 1, 0, 0);                  // reset state visible
    step(0, 1, 13'h0208, 1, 0, 0);
    step(0, 1, 13'h05f1, 1, 0, 0);
    step(0, 1, 13'h06aa, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 13'h1200, 1, 0, 0);                // neg r0 while r0 busy
    step(0, 1, 13'h1200, 1, 1, 0);                  // wb r0, still blocked this cycle
    step(0, 1, 13'h1200, 1, 0, 0);                  // accepted now
    step(0, 1, 13'h1e01, 1, 1, 0);                  // free r0 while offering st
    step(0, 1, 13'h1c00, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 13'h0208, 0, 0, 0);                // backpressure hold
    step(0, 1, 13'h0208, 1, 1, 1);
    step(0, 1, 13'h1e00, 1, 0, 0);
    step(0, 1, 13'h1c00, 1, 0, 0);
    step(1, 0, 13'h0000, 1, 0, 0);
    step(0, 1, 13'h0212, 1, 1, 2);                  // same-edge set/clear of r2
    step(0, 1, 13'h0a1b, 1, 0, 0);
    step(1, 1, 13'h0c24, 1, 0, 0);                  // reset mid-stream
    step(0, 0, 13'h0000, 1, 1, 2);                  // wb to cleared bit is a no-op

    for (int i = 0; i < 3000; i++) begin
      bit rs = ($urandom_range(499) == 0);
      bit iv = ($urandom_range(9) < 8);
      bit or_ = ($urandom_range(3) != 0);
      bit wbv = ($urandom_range(9) < 4);
      step(rs, iv, 13'($urandom), or_, wbv, int'($urandom_range(7)));
    end
    step(0, 0, 13'h0000, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
